// File: rtl/instr_fetch_unit_if.sv
// Instruction delivery bus between the fetch unit (master) and the processor (slave).
// Handshake: a word moves on a rising edge where instr_valid & instr_ready are both high;
// while instr_valid=1 and instr_ready=0 the master holds instruction_out/pc_out stable,
// instr_ready is ignored while instr_valid=0, and the master never waits on instr_ready
// before raising instr_valid.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6
) ();
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction_out;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output instr_valid,
    output instruction_out,
    output pc_out,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instruction_out,
    input  pc_out,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program-memory instruction fetch unit: loadable RAM, PC, 2-entry prefetch buffer and
// a valid/ready issue port; stops on HALT_OPCODE and supports redirect with flush.
module instr_fetch_unit #(
  parameter int         ADDR_W      = 6,
  parameter int         DEPTH       = 2**ADDR_W,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_en,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [31:0]               load_data,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         start_pc,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  instr_fetch_unit_if.master        fetch_bus,
  output logic                      busy,
  output logic                      halted,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] rd_pc;
  logic              rd_valid;

  logic [31:0]       buf_data [2];
  logic [ADDR_W-1:0] buf_pc   [2];
  logic [1:0]        count;

  logic              instr_valid_int;
  logic              pop;
  logic              push;
  logic              issue;
  logic              halt_ret;
  logic              start_act;
  logic              redirect_act;
  logic              load_ok;
  logic [2:0]        occ_after;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_valid_int = (count != 2'd0);
    pop             = instr_valid_int && fetch_bus.instr_ready;
    start_act       = start && ((state == IDLE) || (state == HALTED));
    redirect_act    = redirect && ((state == FETCH) || (state == DRAIN));
    load_ok         = load_en && ((state == IDLE) || (state == HALTED));
    halt_ret        = rd_valid && (rd_data[31:26] == HALT_OPCODE);
    push            = rd_valid && (state == FETCH) && !halt_ret && !redirect_act;
    // Occupancy counted after this cycle's pop so a full-rate consumer never stalls the stream.
    occ_after       = {1'b0, count} - {2'b00, pop} + {2'b00, rd_valid};
    issue           = (state == FETCH) && !redirect_act && !halt_ret && (occ_after < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect)      state_nxt = FETCH;
        else if (halt_ret) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (redirect)            state_nxt = FETCH;
        else if (count == 2'd0)  state_nxt = HALTED;
      end
      HALTED: begin
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == FETCH) || (state == DRAIN);
    halted    = (state == HALTED);
    state_dbg = state;
  end

  // ---------------------------------------------------------------------------
  // Program memory: not reset, synchronous read. Writes only happen outside FETCH,
  // and reads only inside it, so there is no read/write collision to resolve.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr] <= load_data;
    end
    if (issue) begin
      rd_data <= mem[fetch_pc];
    end
  end

  // ---------------------------------------------------------------------------
  // PC, in-flight read tracking and prefetch buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= '0;
      rd_pc       <= '0;
      rd_valid    <= 1'b0;
      count       <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else begin
      // fetch_pc wraps DEPTH-1 -> 0 through natural ADDR_W-bit overflow.
      if (start_act)         fetch_pc <= start_pc;
      else if (redirect_act) fetch_pc <= redirect_pc;
      else if (issue)        fetch_pc <= fetch_pc + ADDR_W'(1);

      rd_valid <= issue;
      if (issue) rd_pc <= fetch_pc;

      if (redirect_act) begin
        count <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              buf_data[0] <= rd_data;
              buf_pc[0]   <= rd_pc;
            end else begin
              buf_data[1] <= rd_data;
              buf_pc[1]   <= rd_pc;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            buf_data[0] <= buf_data[1];
            buf_pc[0]   <= buf_pc[1];
            count       <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              buf_data[0] <= rd_data;
              buf_pc[0]   <= rd_pc;
            end else begin
              buf_data[0] <= buf_data[1];
              buf_pc[0]   <= buf_pc[1];
              buf_data[1] <= rd_data;
              buf_pc[1]   <= rd_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fetch_bus.instr_valid     = instr_valid_int;
  assign fetch_bus.instruction_out = buf_data[0];
  assign fetch_bus.pc_out          = buf_pc[0];

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count != 2'd3);

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
    (fetch_bus.instr_valid && !fetch_bus.instr_ready && !redirect_act) |=>
      (fetch_bus.instr_valid && $stable(fetch_bus.instruction_out) && $stable(fetch_bus.pc_out)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scenario tasks with a transfer scoreboard
// fed by a negedge monitor and a bench-side copy of program memory.
module tb_instr_fetch_unit;
  localparam int ADDR_W = 6;
  localparam int W      = 32 + ADDR_W;

  localparam logic [31:0] I_ADD  = 32'h00221800;
  localparam logic [31:0] I_SUB  = 32'h04812800;
  localparam logic [31:0] I_LOAD = 32'h08C70064;
  localparam logic [31:0] I_ADD2 = 32'h01062000;
  localparam logic [31:0] I_HALT = 32'hFC000000;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [31:0]       load_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_pc = '0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              busy;
  logic              halted;
  logic [1:0]        state_dbg;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) fetch_bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .start_pc    (start_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_bus   (fetch_bus),
    .busy        (busy),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and monitor
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_t[$];
  logic [31:0]  model_mem [2**ADDR_W];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) cyc++;

  // A transfer happens on the next rising edge if valid & ready are high at the negedge.
  always @(negedge clk) begin
    if (reset && fetch_bus.instr_valid && fetch_bus.instr_ready) begin
      obs_q.push_back({fetch_bus.pc_out, fetch_bus.instruction_out});
      obs_t.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    model_mem[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_prog_a();
    load_word(6'd0, I_ADD);
    load_word(6'd1, I_SUB);
    load_word(6'd2, I_LOAD);
    load_word(6'd3, I_ADD2);
    load_word(6'd4, I_HALT);
  endtask

  task automatic start_at(input logic [ADDR_W-1:0] pc);
    start    = 1'b1;
    start_pc = pc;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_seq(input logic [ADDR_W-1:0] pc0, input int n);
    for (int k = 0; k < n; k++) begin
      logic [ADDR_W-1:0] p;
      p = pc0 + ADDR_W'(k);
      exp_q.push_back({p, model_mem[p]});
    end
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (halted) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    fetch_bus.instr_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (fetch_bus.instr_valid !== 1'b0 || fetch_bus.instruction_out !== 32'h0 || fetch_bus.pc_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc=%0d, required 0/0/0",
               fetch_bus.instr_valid, fetch_bus.instruction_out, fetch_bus.pc_out);
    end
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b halted=%b state=%0d, required 0/0/IDLE(0)", busy, halted, state_dbg);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_stream();
    int empty_i;
    int halt_i;
    logic [W-1:0] e;
    logic [W-1:0] o;
    load_prog_a();
    fetch_bus.instr_ready = 1'b1;
    obs_t.delete();
    start_at(6'd0);
    expect_seq(6'd0, 4);
    checks++;
    if (fetch_bus.instr_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_edge0: valid=%b busy=%b, required valid=0 busy=1", fetch_bus.instr_valid, busy);
    end
    tick();
    checks++;
    if (fetch_bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge1: valid=%b, required 0", fetch_bus.instr_valid);
    end
    tick();
    checks++;
    if (fetch_bus.instr_valid !== 1'b1 || fetch_bus.pc_out !== 6'd0 || fetch_bus.instruction_out !== I_ADD) begin
      errors++;
      $display("FAIL basic_edge2: valid=%b pc=%0d instr=%h, required 1/0/%h",
               fetch_bus.instr_valid, fetch_bus.pc_out, fetch_bus.instruction_out, I_ADD);
    end
    empty_i = -1;
    halt_i  = -1;
    for (int i = 0; i < 30; i++) begin
      if (halted) begin
        halt_i = i;
        break;
      end
      if (!fetch_bus.instr_valid && empty_i < 0) empty_i = i;
      tick();
    end
    checks++;
    if (halt_i < 0 || empty_i < 0 || halt_i != empty_i + 1) begin
      errors++;
      $display("FAIL basic_halt_timing: buffer empty at %0d halted at %0d, required halted one cycle after empty",
               empty_i, halt_i);
    end
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL basic_halted_state: busy=%b state=%0d, required 0/HALTED(3)", busy, state_dbg);
    end
    checks++;
    if (obs_t.size() != 4 || obs_t[3] - obs_t[0] != 3) begin
      errors++;
      $display("FAIL basic_back_to_back: %0d transfers over span %0d cycles, required 4 over 3",
               obs_t.size(), (obs_t.size() > 0) ? obs_t[obs_t.size()-1] - obs_t[0] : -1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL basic_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL basic_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL basic_extra: %0d extra transfers, first pc=%0d instr=%h", obs_q.size(), obs_q[0][W-1:32], obs_q[0][31:0]);
      obs_q.delete();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    fetch_bus.instr_ready = 1'b0;
    start_at(6'd0);
    expect_seq(6'd0, 4);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (fetch_bus.instr_valid !== 1'b1 || fetch_bus.instruction_out !== I_ADD || fetch_bus.pc_out !== 6'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%0d, required 1/%h/0",
                 k, fetch_bus.instr_valid, fetch_bus.instruction_out, fetch_bus.pc_out, I_ADD);
      end
      tick();
    end
    fetch_bus.instr_ready = 1'b1;
    wait_halted(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_halted: halted=%b after budget, required 1", halted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL stall_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL stall_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL stall_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
      obs_q.delete();
    end
  endtask

  task automatic test_redirect();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    load_word(6'd2, I_HALT);
    load_word(6'd10, I_ADD2);
    load_word(6'd11, I_HALT);
    fetch_bus.instr_ready = 1'b1;
    start_at(6'd0);
    tick();
    tick();
    exp_q.push_back({6'd0, model_mem[0]});
    exp_q.push_back({6'd10, model_mem[10]});
    // Redirect lands on the same edge that transfers pc 0.
    redirect    = 1'b1;
    redirect_pc = 6'd10;
    tick();
    redirect = 1'b0;
    checks++;
    if (fetch_bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: valid=%b pc=%0d after redirect edge, required valid=0", fetch_bus.instr_valid, fetch_bus.pc_out);
    end
    tick();
    checks++;
    if (fetch_bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_edge1: valid=%b, required 0", fetch_bus.instr_valid);
    end
    tick();
    checks++;
    if (fetch_bus.instr_valid !== 1'b1 || fetch_bus.pc_out !== 6'd10 || fetch_bus.instruction_out !== I_ADD2) begin
      errors++;
      $display("FAIL redir_edge2: valid=%b pc=%0d instr=%h, required 1/10/%h",
               fetch_bus.instr_valid, fetch_bus.pc_out, fetch_bus.instruction_out, I_ADD2);
    end
    wait_halted(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL redir_halted: halted=%b after budget, required 1", halted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL redir_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL redir_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL redir_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
      obs_q.delete();
    end
    load_word(6'd2, I_LOAD);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    load_word(6'd62, I_ADD);
    load_word(6'd63, I_SUB);
    load_word(6'd0, I_LOAD);
    load_word(6'd1, I_HALT);
    fetch_bus.instr_ready = 1'b1;
    start_at(6'd62);
    expect_seq(6'd62, 3);
    wait_halted(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_halted: halted=%b after budget, required 1", halted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL wrap_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
      obs_q.delete();
    end
    load_word(6'd0, I_ADD);
    load_word(6'd1, I_SUB);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    fetch_bus.instr_ready = 1'b0;
    start_at(6'd0);
    tick();
    tick();
    checks++;
    if (fetch_bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b before reset, required 1", fetch_bus.instr_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (fetch_bus.instr_valid !== 1'b0 || fetch_bus.instruction_out !== 32'h0 || fetch_bus.pc_out !== '0 ||
        busy !== 1'b0 || halted !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b instr=%h pc=%0d busy=%b halted=%b state=%0d, required all 0",
               fetch_bus.instr_valid, fetch_bus.instruction_out, fetch_bus.pc_out, busy, halted, state_dbg);
    end
    tick();
    reset = 1'b1;
    tick();
    fetch_bus.instr_ready = 1'b1;
    start_at(6'd0);
    expect_seq(6'd0, 4);
    wait_halted(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_halted: halted=%b after budget, required 1", halted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rstmid_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL rstmid_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
      obs_q.delete();
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    for (int rep = 0; rep < 3; rep++) begin
      fetch_bus.instr_ready = 1'($urandom_range(0, 1));
      start_at(6'd0);
      expect_seq(6'd0, 4);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
        if (halted) begin
          ok = 1'b1;
          break;
        end
        fetch_bus.instr_ready = 1'($urandom_range(0, 1));
        tick();
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_halted[%0d]: halted=%b after budget, required 1", rep, halted);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
          errors++;
          $display("FAIL rand_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL rand_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
          end
        end
      end
      checks++;
      if (obs_q.size() != 0) begin
        errors++;
        $display("FAIL rand_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
        obs_q.delete();
      end
    end
  endtask

  task automatic test_load_while_busy();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    fetch_bus.instr_ready = 1'b1;
    start_at(6'd0);
    expect_seq(6'd0, 4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busyload_busy: busy=%b during write attempt, required 1", busy);
    end
    // Model memory is deliberately not updated: this write must be dropped.
    load_en   = 1'b1;
    load_addr = 6'd0;
    load_data = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    wait_halted(30, ok);
    start_at(6'd0);
    expect_seq(6'd0, 4);
    wait_halted(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busyload_halted: halted=%b after budget, required 1", halted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL busyload_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL busyload_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL busyload_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
      obs_q.delete();
    end
  endtask

  task automatic test_start_with_load();
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] o;
    fetch_bus.instr_ready = 1'b1;
    // Write, start and redirect on one edge in HALTED: write lands, start wins, redirect ignored.
    load_en     = 1'b1;
    load_addr   = 6'd0;
    load_data   = 32'h10A00005;
    model_mem[0] = 32'h10A00005;
    start       = 1'b1;
    start_pc    = 6'd0;
    redirect    = 1'b1;
    redirect_pc = 6'd10;
    tick();
    load_en  = 1'b0;
    start    = 1'b0;
    redirect = 1'b0;
    expect_seq(6'd0, 4);
    wait_halted(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL startload_halted: halted=%b after budget, required 1", halted);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL startload_seq: missing transfer, required pc=%0d instr=%h", e[W-1:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL startload_seq: got pc=%0d instr=%h, required pc=%0d instr=%h", o[W-1:32], o[31:0], e[W-1:32], e[31:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL startload_extra: %0d extra transfers, first pc=%0d", obs_q.size(), obs_q[0][W-1:32]);
      obs_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    fetch_bus.instr_ready = 1'b0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random_ready();
    test_load_while_busy();
    test_start_with_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-issue block that drives the pipelined_processor instruction_in port from an on-chip program memory, replacing bench-driven instruction streams.
- Holds a loadable program RAM and a program counter, prefetches into a 2-entry buffer, and presents instructions over a valid/ready handshake.
- Supports redirect (PC change with flush) and a HALT opcode that stops the stream.
- Instruction format matches the processor: opcode[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0].

Parameters:
- ADDR_W, 6, program memory address width; word addressed, PC increments by 1.
- DEPTH, 64, program memory words (2**ADDR_W).
- HALT_OPCODE, 6'b111111, opcode that terminates fetching.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_en  input  1  program-memory write strobe.
- load_addr  input  ADDR_W  write address.
- load_data  input  32  write data.
- start  input  1  one-cycle pulse; begin fetching at start_pc.
- start_pc  input  ADDR_W  start address.
- redirect  input  1  one-cycle pulse; flush and refetch from redirect_pc.
- redirect_pc  input  ADDR_W  redirect target.
- instr_valid  output  1  instruction_out/pc_out hold a valid instruction.
- instr_ready  input  1  consumer accepts this cycle.
- instruction_out  output  32  instruction to processor.
- pc_out  output  ADDR_W  address of instruction_out.
- busy  output  1  state is FETCH or DRAIN.
- halted  output  1  HALT reached and buffer drained.

Behaviour:
- Reset (reset=0, async): state IDLE; instr_valid=0, instruction_out=0, pc_out=0, busy=0, halted=0; buffer empty, in-flight read cancelled. Memory contents are not reset.
- Memory: synchronous read, 1-cycle latency.
  - Writes are accepted only in IDLE or HALTED.
  - load_en in FETCH/DRAIN is ignored.
- States:
  - IDLE: start -> FETCH, fetch_pc=start_pc.
  - FETCH: issue a read each cycle while (buffer occupancy + in-flight) < 2; fetch_pc increments and wraps DEPTH-1 -> 0.
    - A returning word with opcode==HALT_OPCODE is discarded, not buffered. Fetching stops, any later in-flight word is discarded, and the state goes to DRAIN.
  - DRAIN: no reads issued; -> HALTED the cycle after the buffer empties.
  - HALTED: halted=1, busy=0; start -> FETCH (halted cleared).
- Start latency: start sampled at edge 0, read issued at edge 1, buffered at edge 2. instr_valid=1 after edge 2.
- Handshake:
  - A transfer occurs on an edge with instr_valid & instr_ready.
  - While instr_valid=1 and instr_ready=0, instruction_out and pc_out hold stable.
  - The buffer sustains 1 instruction/cycle with instr_ready held high.
  - instr_ready is don't-care when instr_valid=0.
- Redirect (FETCH or DRAIN only; ignored in IDLE/HALTED):
  - A transfer on the same edge completes first.
  - Then the buffer and in-flight read are flushed, fetch_pc=redirect_pc, state=FETCH (HALT detection cancelled).
  - instr_valid=0 the cycle after; first redirected instruction valid 2 edges after the redirect edge.
- Simultaneous events:
  - start+redirect in IDLE: start wins.
  - start in FETCH/DRAIN: ignored.
  - load_en+start in IDLE: the write completes on that edge; a read of that address 1 edge later sees new data.
- Reset asserted mid-stream: immediate return to reset values regardless of handshake state.
- pc_out always equals the memory address the presented instruction was read from, including across wrap-around.

Test Plan:
- Load 0:0x00221800 (ADD R1,R2,R3), 1:0x04812800 (SUB R4,R1,R5), 2:0x08C70064 (LOAD R6,100(R7)), 3:0x01062000 (ADD R8,R6,R4), 4:0xFC000000 (HALT); start_pc=0, instr_ready=1.
  - Required: valid after edge 2, four consecutive transfers with pc_out 0..3; HALT not delivered; halted=1 one cycle after buffer empty.
- Same program, instr_ready=0 for 5 cycles after first valid.
  - Required: instruction_out holds 0x00221800 / pc_out=0 throughout; no drop or duplicate once ready rises.
- Program {0:0x00221800, 1:0x04812800, 2:HALT, 10:0x01062000, 11:HALT}; after the transfer of pc 0, redirect to 10.
  - Required: pc 1 not delivered; next transfer pc_out=10 value 0x01062000, 2 edges after redirect; then halted=1.
- start_pc=62 with words at 62, 63, 0, then HALT at 1.
  - Required: pc_out sequence 62, 63, 0; halted=1.
- Assert reset low while instr_valid=1 and instr_ready=0.
  - Required: all outputs 0 immediately, state IDLE.
  - Memory retained: a new start at 0 replays 0x00221800.
- load_en to address 0 with 0xDEADBEEF while busy.
  - Required: ignored; after HALTED, restart at 0 still presents 0x00221800.
